// File: rtl/kurm_alu_pkg.sv
// Shared definitions for the registered KURM ALU: op codes, FSM states and
// the result flag bundle.
package kurm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic c_out;
        logic overflow;
        logic lt;
        logic eq;
        logic gt;
    } flags_t;

endpackage

// File: rtl/kurm_alu_mul_iter.sv
// Iterative shift-add unsigned multiplier. The first partial product is taken
// at start, the remaining WIDTH-1 on following cycles; done marks the last one.
module kurm_alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] acc_step;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    // On the final iteration the completed product is the step sum itself.
    assign product  = acc_step;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done     = 1'b0;
        if (start) begin
            acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_d = b >> 1;
            cnt_d    = CW'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                done   = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/kurm_alu_seq.sv
// Registered KURM ALU with valid/ready handshakes. Define KURM_ALU_MUL_EN to
// build the multi-cycle MUL; otherwise op 100 acts as a reserved op.
module kurm_alu_seq
    import kurm_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             c_out,
    output logic             overflow,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] z_q, z_d;
    flags_t           flags_q, flags_d;

    logic             accept;
    logic             is_mul;
    logic [WIDTH:0]   sum_add, sum_sub;
    logic [WIDTH-1:0] res_z;
    flags_t           res_flags;

    assign in_ready = !reset && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign sum_add  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c_in};
    assign sum_sub  = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};

`ifdef KURM_ALU_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [2:0]         cmp_pend_q, cmp_pend_d;

    assign is_mul    = (op == OP_MUL);
    assign mul_start = accept && is_mul;

    kurm_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (x),
        .b       (y),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        res_z              = '0;
        res_flags.c_out    = 1'b0;
        res_flags.overflow = 1'b0;
        res_flags.lt       = (x < y);
        res_flags.eq       = (x == y);
        res_flags.gt       = (x > y);
        case (op)
            OP_AND: res_z = x & y;
            OP_OR:  res_z = x | y;
            OP_ADD: begin
                res_z              = sum_add[WIDTH-1:0];
                res_flags.c_out    = sum_add[WIDTH];
                res_flags.overflow = (x[MSB] == y[MSB]) && (sum_add[MSB] != x[MSB]);
            end
            OP_SUB: begin
                res_z              = sum_sub[WIDTH-1:0];
                res_flags.c_out    = sum_sub[WIDTH];
                res_flags.overflow = (x[MSB] != y[MSB]) && (sum_sub[MSB] != x[MSB]);
            end
            OP_SLT: res_z = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_MUL: res_z = '0;
            default: res_z = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        z_d         = z_q;
        flags_d     = flags_q;
`ifdef KURM_ALU_MUL_EN
        cmp_pend_d  = cmp_pend_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (is_mul) begin
                state_d = ST_MUL;
`ifdef KURM_ALU_MUL_EN
                cmp_pend_d = {res_flags.lt, res_flags.eq, res_flags.gt};
`endif
            end else begin
                z_d         = res_z;
                flags_d     = res_flags;
                out_valid_d = 1'b1;
            end
        end
`ifdef KURM_ALU_MUL_EN
        // The output was free or drained when the MUL was accepted, so this never overwrites.
        if ((state_q == ST_MUL) && mul_done) begin
            state_d          = ST_IDLE;
            z_d              = mul_product[WIDTH-1:0];
            flags_d.c_out    = 1'b0;
            flags_d.overflow = |mul_product[2*WIDTH-1:WIDTH];
            flags_d.lt       = cmp_pend_q[2];
            flags_d.eq       = cmp_pend_q[1];
            flags_d.gt       = cmp_pend_q[0];
            out_valid_d      = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            flags_q     <= flags_d;
        end
    end

`ifdef KURM_ALU_MUL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_pend_q <= '0;
        end else begin
            cmp_pend_q <= cmp_pend_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign c_out     = flags_q.c_out;
    assign overflow  = flags_q.overflow;
    assign lt        = flags_q.lt;
    assign eq        = flags_q.eq;
    assign gt        = flags_q.gt;

endmodule

// File: tb/tb_kurm_alu_seq.sv
// Directed self-checking bench for kurm_alu_seq (WIDTH=16); follows
// KURM_ALU_MUL_EN to choose between MUL and reserved-op expectations.
module tb_kurm_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, c_in;
    logic [2:0]   op;
    logic [W-1:0] x, y, z;
    logic         out_valid, out_ready, c_out, overflow, lt, eq, gt;

    int errors = 0;
    int checks = 0;

    logic [20:0] got, exp_v;

    always #5 clk = ~clk;

    kurm_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .c_out     (c_out),
        .overflow  (overflow),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        x = a;
        y = b;
        c_in = ci;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; op = 3'b010; x = 16'h0001; y = 16'h0002;
        c_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        checks++;
        if (got !== 21'h0) begin
            errors++; $display("FAIL reset_outputs got=%h want=%h", got, 21'h0);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset got=%b want=1", in_ready);
        end
        $display("txn reset done in_ready=%b", in_ready);
    endtask

    task automatic test_add_sub();
        drive(3'b010, 16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL add_wrap got=%h want=%h", got, exp_v);
        end
        $display("txn ADD FFFF+0001 z=%h c=%b v=%b", z, c_out, overflow);
        drive(3'b011, 16'h8000, 16'h0001, 1'b0);
        @(posedge clk); #1;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL sub_ovf got=%h want=%h", got, exp_v);
        end
        $display("txn SUB 8000-0001 z=%h c=%b v=%b", z, c_out, overflow);
        drive(3'b010, 16'h7FFF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL add_ovf got=%h want=%h", got, exp_v);
        end
        $display("txn ADD 7FFF+0001 z=%h c=%b v=%b", z, c_out, overflow);
    endtask

    task automatic test_back_to_back();
        drive(3'b010, 16'h0003, 16'h0004, 1'b1);
        @(posedge clk); #1;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL b2b_add got=%h want=%h", got, exp_v);
        end
        $display("txn ADD 0003+0004+1 z=%h", z);
        drive(3'b000, 16'hF0F0, 16'h0FF0, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL b2b_and got=%h want=%h", got, exp_v);
        end
        $display("txn AND F0F0&0FF0 z=%h", z);
    endtask

    task automatic test_mul();
`ifdef KURM_ALU_MUL_EN
        int lat;
        int ready_bad;
        drive(3'b100, 16'h0123, 16'h0010, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; ready_bad = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0) ready_bad++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != W) begin
            errors++; $display("FAIL mul_latency got=%0d want=%0d", lat, W);
        end
        checks++;
        if (ready_bad != 0) begin
            errors++; $display("FAIL mul_busy_ready got=%0d high cycles want=0", ready_bad);
        end
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h1230, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL mul_small got=%h want=%h", got, exp_v);
        end
        $display("txn MUL 0123*0010 z=%h v=%b lat=%0d", z, overflow, lat);
        drive(3'b100, 16'h0100, 16'h0100, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        checks++;
        if (got !== exp_v || lat != W) begin
            errors++; $display("FAIL mul_high got=%h lat=%0d want=%h lat=%0d", got, lat, exp_v, W);
        end
        $display("txn MUL 0100*0100 z=%h v=%b lat=%0d", z, overflow, lat);
`else
        drive(3'b100, 16'h0123, 16'h0010, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL mul_disabled got=%h want=%h", got, exp_v);
        end
        $display("txn op100 (no MUL) z=%h", z);
`endif
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        drive(3'b010, 16'h0005, 16'h000A, 1'b0);
        @(posedge clk); #1;
        op = 3'b001; x = 16'h0123; y = 16'hF1F2; c_in = 1'b0;
        exp_v = {1'b1, 16'h000F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = {out_valid, z, c_out, overflow, lt, eq, gt};
            checks++;
            if (got !== exp_v || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got=%h rdy=%b want=%h rdy=0", i, got, in_ready, exp_v);
            end
        end
        $display("txn ADD 0005+000A held z=%h", z);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'hF1F3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL bp_or got=%h want=%h", got, exp_v);
        end
        $display("txn OR 0123|F1F2 z=%h", z);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_valid got=%b want=0", out_valid);
        end
    endtask

    task automatic test_reset_abort();
`ifdef KURM_ALU_MUL_EN
        int seen;
        drive(3'b100, 16'h0003, 16'h0003, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_ready got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
        end
        seen = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || z !== 16'h0000) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL abort_stale got=%0d stale cycles want=0", seen);
        end
        $display("txn MUL aborted by reset, stale=%0d", seen);
`else
        @(negedge clk);
        out_ready = 1'b0;
        drive(3'b010, 16'h0001, 16'h0001, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 16'h0000) begin
            errors++;
            $display("FAIL abort_pending got rdy=%b ov=%b z=%h want 1 0 0000", in_ready, out_valid, z);
        end
        $display("txn reset cleared pending result");
`endif
    endtask

    task automatic test_slt_reserved();
        drive(3'b111, 16'h0009, 16'h000A, 1'b0);
        @(posedge clk); #1;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL slt_true got=%h want=%h", got, exp_v);
        end
        $display("txn SLT 9,10 z=%h", z);
        drive(3'b111, 16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL slt_unsigned got=%h want=%h", got, exp_v);
        end
        $display("txn SLT FFFF,0001 z=%h", z);
        drive(3'b101, 16'h1234, 16'h1234, 1'b1);
        @(posedge clk); #1;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL rsv101 got=%h want=%h", got, exp_v);
        end
        $display("txn op101 1234,1234 z=%h eq=%b", z, eq);
        drive(3'b110, 16'h0001, 16'h0002, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = {out_valid, z, c_out, overflow, lt, eq, gt};
        exp_v = {1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL rsv110 got=%h want=%h", got, exp_v);
        end
        $display("txn op110 0001,0002 z=%h lt=%b", z, lt);
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_abort();
        test_slt_reserved();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
